// File: rtl/kilit_denetleyici.sv
// Sequencer sharing the klavye_dinle password checker between the key stream and
// an admin password loader; enforces the penalty wait after a lock and then releases it.
//   state | meaning
//   BOS   | idle, forwards keys; lock > admin > key priority
//   PROG  | streams the latched admin password, one byte per cycle
//   CEZA  | penalty wait, kalan units of TICK_DIV cycles
//   BIRAK | lock release pulse, wait for checker to drop kitle
module kilit_denetleyici #(
  parameter int SIFRE_UZ = 4,
  parameter int TICK_DIV = 100_000_000
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_kb_valid,
  input  logic [7:0]              i_kb_data,
  input  logic                    i_adm_req,
  input  logic [8*SIFRE_UZ-1:0]   i_adm_sifre,
  output logic                    o_adm_ack,
  input  logic                    i_kitle_in,
  input  logic [7:0]              i_ceza_in,
  output logic                    o_karakter_aktif,
  output logic [7:0]              o_karakter,
  output logic                    o_sifre_degis,
  output logic [7:0]              o_sifre_kanali,
  output logic                    o_kilit_temizle,
  output logic                    o_mesgul,
  output logic [7:0]              o_kalan,
  output logic [7:0]              o_dusen_tus
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BW = $clog2(SIFRE_UZ + 1);
  localparam logic [TW-1:0] TICK_SON = TW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BEAT_SON = BW'(SIFRE_UZ);

  typedef enum logic [1:0] {BOS, PROG, CEZA, BIRAK} durum_t;

  durum_t                r_state, w_state_nxt;
  logic [8*SIFRE_UZ-1:0] r_sifre, w_sifre;
  logic [BW-1:0]         r_beat, w_beat;
  logic [TW-1:0]         r_tick, w_tick;
  logic [7:0]            r_kalan, w_kalan;
  logic [7:0]            r_bekle, w_bekle;
  logic [7:0]            r_karakter, w_karakter;
  logic [7:0]            r_kanal, w_kanal;
  logic [7:0]            r_dusen, w_dusen;
  logic                  r_ack, w_ack;
  logic                  r_aktif, w_aktif;
  logic                  r_degis, w_degis;
  logic                  r_temizle, w_temizle;
  logic                  r_mesgul;
  logic                  w_tick_son;
  logic                  w_drop;
  logic [7:0]            w_ceza_yuk;

  assign w_tick_son = (r_tick == TICK_SON);
  assign w_ceza_yuk = (i_ceza_in == 8'd0) ? 8'd1 : i_ceza_in;
  assign w_drop     = i_kb_valid && ((r_state != BOS) || i_kitle_in || i_adm_req);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= BOS;
      r_sifre    <= '0;
      r_beat     <= '0;
      r_tick     <= '0;
      r_kalan    <= '0;
      r_bekle    <= '0;
      r_karakter <= '0;
      r_kanal    <= '0;
      r_dusen    <= '0;
      r_ack      <= 1'b0;
      r_aktif    <= 1'b0;
      r_degis    <= 1'b0;
      r_temizle  <= 1'b0;
      r_mesgul   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_sifre    <= w_sifre;
      r_beat     <= w_beat;
      r_tick     <= w_tick;
      r_kalan    <= w_kalan;
      r_bekle    <= w_bekle;
      r_karakter <= w_karakter;
      r_kanal    <= w_kanal;
      r_dusen    <= w_dusen;
      r_ack      <= w_ack;
      r_aktif    <= w_aktif;
      r_degis    <= w_degis;
      r_temizle  <= w_temizle;
      r_mesgul   <= (w_state_nxt != BOS);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      BOS: begin
        if (i_kitle_in)     w_state_nxt = CEZA;
        else if (i_adm_req) w_state_nxt = PROG;
      end
      PROG:  if (r_beat == BEAT_SON) w_state_nxt = BOS;
      CEZA:  if (w_tick_son && (r_kalan == 8'd1)) w_state_nxt = BIRAK;
      BIRAK: begin
        if (!i_kitle_in)             w_state_nxt = BOS;
        else if (r_bekle == 8'd254)  w_state_nxt = CEZA;
      end
      default: w_state_nxt = BOS;
    endcase
  end

  always_comb begin
    w_sifre    = r_sifre;
    w_beat     = r_beat;
    w_tick     = r_tick;
    w_kalan    = r_kalan;
    w_bekle    = r_bekle;
    w_karakter = r_karakter;
    w_kanal    = r_kanal;
    w_ack      = 1'b0;
    w_aktif    = 1'b0;
    w_degis    = 1'b0;
    w_temizle  = 1'b0;
    w_dusen    = (w_drop && (r_dusen != 8'hFF)) ? r_dusen + 8'd1 : r_dusen;
    case (r_state)
      BOS: begin
        if (i_kitle_in) begin
          w_kalan = w_ceza_yuk;
          w_tick  = '0;
        end else if (i_adm_req) begin
          // first beat leaves on the entry edge; the copy is shifted MSB-first
          w_degis = 1'b1;
          w_kanal = i_adm_sifre[8*SIFRE_UZ-1 -: 8];
          w_sifre = i_adm_sifre << 8;
          w_beat  = BW'(1);
        end else if (i_kb_valid) begin
          w_aktif    = 1'b1;
          w_karakter = i_kb_data;
        end
      end
      PROG: begin
        if (r_beat == BEAT_SON) begin
          w_ack  = 1'b1;
          w_beat = '0;
        end else begin
          w_degis = 1'b1;
          w_kanal = r_sifre[8*SIFRE_UZ-1 -: 8];
          w_sifre = r_sifre << 8;
          w_beat  = r_beat + BW'(1);
        end
      end
      CEZA: begin
        if (w_tick_son) begin
          w_tick  = '0;
          w_kalan = r_kalan - 8'd1;
          if (r_kalan == 8'd1) begin
            w_temizle = 1'b1;
            w_bekle   = 8'd0;
          end
        end else begin
          w_tick = r_tick + TW'(1);
        end
      end
      BIRAK: begin
        if (i_kitle_in) begin
          if (r_bekle == 8'd254) begin
            w_kalan = w_ceza_yuk;
            w_tick  = '0;
          end else begin
            w_bekle = r_bekle + 8'd1;
          end
        end
      end
      default: ;
    endcase
  end

  assign o_adm_ack        = r_ack;
  assign o_karakter_aktif = r_aktif;
  assign o_karakter       = r_karakter;
  assign o_sifre_degis    = r_degis;
  assign o_sifre_kanali   = r_kanal;
  assign o_kilit_temizle  = r_temizle;
  assign o_mesgul         = r_mesgul;
  assign o_kalan          = r_kalan;
  assign o_dusen_tus      = r_dusen;

endmodule

// File: tb/tb_kilit_denetleyici.sv
// Directed/randomized bench for kilit_denetleyici with SIFRE_UZ=4, TICK_DIV=4;
// the bench plays the checker role (drops kitle once the release pulse appears).
module tb_kilit_denetleyici;
  localparam int SU = 4;
  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        kb_valid = 1'b0;
  logic [7:0]  kb_data = 8'h00;
  logic        adm_req = 1'b0;
  logic [31:0] sifre = 32'h0;
  logic        kitle = 1'b0;
  logic [7:0]  ceza = 8'h00;
  logic        adm_ack, aktif, degis, temizle, mesgul;
  logic [7:0]  karakter, kanal, kalan, dusen;

  int n_chk = 0;
  int n_err = 0;
  int dusen_m = 0;

  kilit_denetleyici #(.SIFRE_UZ(SU), .TICK_DIV(TD)) dut (
    .i_clk(clk), .i_rst(rst), .i_kb_valid(kb_valid), .i_kb_data(kb_data),
    .i_adm_req(adm_req), .i_adm_sifre(sifre), .o_adm_ack(adm_ack),
    .i_kitle_in(kitle), .i_ceza_in(ceza), .o_karakter_aktif(aktif),
    .o_karakter(karakter), .o_sifre_degis(degis), .o_sifre_kanali(kanal),
    .o_kilit_temizle(temizle), .o_mesgul(mesgul), .o_kalan(kalan),
    .o_dusen_tus(dusen)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // step where any presented key is known to be discarded by the sequencer
  task automatic stepk();
    if (kb_valid) dusen_m = (dusen_m < 255) ? dusen_m + 1 : 255;
    step();
  endtask

  // called just after the edge that entered the load: beat 0 is visible
  task automatic prog_check(input logic [31:0] pw, input string tag);
    for (int b = 0; b < SU; b++) begin
      if (b > 0) step();
      chk({tag, "_degis"}, degis, 1);
      chk({tag, "_kanal"}, kanal, (pw >> (8 * (SU - 1 - b))) & 32'hFF);
      chk({tag, "_ack_early"}, adm_ack, 0);
      sifre = $urandom;
    end
    step();
    chk({tag, "_ack"}, adm_ack, 1);
    chk({tag, "_degis_off"}, degis, 0);
    adm_req = 1'b0;
    step();
    chk({tag, "_ack_pulse"}, adm_ack, 0);
    chk({tag, "_idle"}, mesgul, 0);
  endtask

  // lock with penalty k (0 means 1); n keys dropped during the wait
  task automatic lock_run(input int k, input int n, input string tag);
    int keff;
    keff = (k == 0) ? 1 : k;
    kitle = 1'b1;
    ceza = 8'(k);
    step();
    chk({tag, "_kalan0"}, kalan, keff);
    for (int i = 1; i <= TD * keff; i++) begin
      kb_valid = (i <= n);
      kb_data = 8'($urandom);
      stepk();
      if (i < TD * keff) begin
        chk({tag, "_kalan"}, kalan, keff - i / TD);
        chk({tag, "_temizle_early"}, temizle, 0);
        chk({tag, "_no_key"}, aktif, 0);
      end
    end
    chk({tag, "_temizle"}, temizle, 1);
    chk({tag, "_kalan_end"}, kalan, 0);
    kitle = 1'b0;
    kb_valid = 1'b0;
    step();
    chk({tag, "_release"}, mesgul, 0);
    chk({tag, "_temizle_pulse"}, temizle, 0);
    chk({tag, "_dusen"}, dusen, dusen_m);
  endtask

  initial begin
    logic [31:0] pw;
    int v;
    int k;

    #2;
    chk("rst_mesgul", mesgul, 0);
    chk("rst_kalan", kalan, 0);
    chk("rst_degis", degis, 0);
    chk("rst_dusen", dusen, 0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_idle", mesgul, 0);

    // admin loads: directed pattern then random ones
    for (int t = 0; t < 3; t++) begin
      pw = (t == 0) ? 32'h61626364 : $urandom;
      sifre = pw;
      adm_req = 1'b1;
      step();
      chk("prog_busy", mesgul, 1);
      prog_check(pw, "prog");
    end

    // key stream: directed then random with gaps
    for (int i = 0; i < 4; i++) begin
      kb_valid = 1'b1;
      kb_data = 8'h64 - 8'(i);
      step();
      chk("key_aktif", aktif, 1);
      chk("key_data", karakter, 32'h64 - i);
    end
    for (int i = 0; i < 40; i++) begin
      v = $urandom_range(0, 1);
      kb_valid = v[0];
      kb_data = 8'($urandom);
      step();
      chk("rkey_aktif", aktif, v);
      if (v == 1) chk("rkey_data", karakter, kb_data);
    end
    kb_valid = 1'b0;
    step();
    chk("key_idle", aktif, 0);
    chk("key_no_drop", dusen, dusen_m);

    lock_run(3, 5, "lock3");
    chk("lock3_five", dusen, 5);
    k = $urandom_range(1, 6);
    lock_run(k, $urandom_range(0, 4 * k), "lockr");

    // lock, admin and key in the same cycle
    pw = $urandom;
    sifre = pw;
    kitle = 1'b1;
    ceza = 8'd1;
    adm_req = 1'b1;
    kb_valid = 1'b1;
    stepk();
    kb_valid = 1'b0;
    chk("tri_kalan", kalan, 1);
    chk("tri_degis", degis, 0);
    chk("tri_aktif", aktif, 0);
    chk("tri_dusen", dusen, dusen_m);
    for (int i = 1; i < TD; i++) step();
    chk("tri_wait", kalan, 1);
    step();
    chk("tri_temizle", temizle, 1);
    kitle = 1'b0;
    step();
    chk("tri_bos", mesgul, 0);
    step();
    prog_check(pw, "tri_prog");

    // reset in the middle of a load
    sifre = $urandom;
    adm_req = 1'b1;
    step();
    step();
    step();
    chk("mid_degis", degis, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_degis", degis, 0);
    chk("mid_rst_mesgul", mesgul, 0);
    chk("mid_rst_kanal", kanal, 0);
    adm_req = 1'b0;
    dusen_m = 0;
    step();
    step();
    chk("mid_rst_ack", adm_ack, 0);
    rst = 1'b0;
    step();
    chk("mid_rst_idle", mesgul, 0);
    chk("mid_rst_dusen", dusen, 0);

    // ceza_in=0, hold lock through the release window, flood keys
    kitle = 1'b1;
    ceza = 8'd0;
    kb_valid = 1'b1;
    stepk();
    chk("z_kalan", kalan, 1);
    for (int i = 1; i < TD; i++) stepk();
    chk("z_wait", kalan, 1);
    stepk();
    chk("z_temizle", temizle, 1);
    ceza = 8'd20;
    for (int i = 0; i < 254; i++) stepk();
    chk("z_hold_busy", mesgul, 1);
    chk("z_hold_kalan", kalan, 0);
    stepk();
    chk("z_reenter", kalan, 20);
    for (int i = 1; i < 20 * TD; i++) stepk();
    chk("z_last", kalan, 1);
    stepk();
    chk("z_temizle2", temizle, 1);
    kitle = 1'b0;
    kb_valid = 1'b0;
    step();
    chk("z_idle", mesgul, 0);
    chk("z_dusen_sat", dusen, dusen_m);
    chk("z_dusen_255", dusen, 255);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
